// File: rtl/sp_fetch_pkg.sv
// Shared types and default geometry for the S' block fetcher.
package sp_fetch_pkg;

    typedef enum logic [1:0] {
        PLANE_Y    = 2'd0,
        PLANE_U    = 2'd1,
        PLANE_V    = 2'd2,
        PLANE_RSVD = 2'd3
    } plane_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    localparam int DEF_SRAM_LAT  = 2;
    localparam int DEF_Y_BASE    = 27648;
    localparam int DEF_U_BASE    = 55296;
    localparam int DEF_V_BASE    = 69120;
    localparam int DEF_Y_STRIDE  = 320;
    localparam int DEF_UV_STRIDE = 160;
    localparam int DEF_Y_BLK     = 16;
    localparam int DEF_UV_BLK    = 8;
    localparam int DEF_DPA_W     = 8;

    // Largest scan index for a block edge of n samples.
    function automatic logic [3:0] blk_last_idx(input logic [4:0] n);
        return 4'(n - 5'd1);
    endfunction

endpackage

// File: rtl/sp_block_fetch_if.sv
// Request, SRAM read and DP-RAM write signals of the S' block fetcher.
// With SP_BLOCK_FETCH_CHECKSUM_EN defined the bundle also carries checksum.
interface sp_block_fetch_if #(
    parameter int DPA_W = 8
);
    logic             start;
    logic [1:0]       plane;
    logic [4:0]       Rb;
    logic [5:0]       Cb;
    logic             abort;
    logic             sram_gnt;
    logic [15:0]      SRAM_read_data;
    logic [17:0]      SRAM_address;
    logic             DP_RAM_we;
    logic [DPA_W-1:0] DP_RAM_address;
    logic [31:0]      DP_RAM_write_data;
    logic             busy;
    logic             done;
`ifdef SP_BLOCK_FETCH_CHECKSUM_EN
    logic [15:0]      checksum;
`endif

    // Fetcher side.
    modport slave (
`ifdef SP_BLOCK_FETCH_CHECKSUM_EN
        output checksum,
`endif
        input  start, plane, Rb, Cb, abort, sram_gnt, SRAM_read_data,
        output SRAM_address, DP_RAM_we, DP_RAM_address, DP_RAM_write_data, busy, done
    );

    // Requester / memory side.
    modport master (
`ifdef SP_BLOCK_FETCH_CHECKSUM_EN
        input  checksum,
`endif
        output start, plane, Rb, Cb, abort, sram_gnt, SRAM_read_data,
        input  SRAM_address, DP_RAM_we, DP_RAM_address, DP_RAM_write_data, busy, done
    );
endinterface

// File: rtl/sp_addr_gen.sv
// Column-major block scan counters and SRAM address arithmetic.
// The address is formed in 19 bits and wrapped to 18.
module sp_addr_gen
    import sp_fetch_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        clr,
    input  logic        step,
    input  logic [4:0]  blk_n,
    input  logic [17:0] base,
    input  logic [8:0]  stride,
    input  logic [4:0]  rb,
    input  logic [5:0]  cb,
    output logic [17:0] addr,
    output logic        last
);
    logic [3:0]  ri_q, ci_q;
    logic [3:0]  n_m1;
    logic [18:0] row, sum;

    assign n_m1 = blk_last_idx(blk_n);
    assign last = (ri_q == n_m1) && (ci_q == n_m1);

    // Advance ri fastest, then ci, once per issued address.
    always_ff @(posedge Clock or negedge Resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Resetn) begin
            ri_q <= '0;
            ci_q <= '0;
        end else if (clr) begin
            ri_q <= '0;
            ci_q <= '0;
        end else if (step) begin
            if (ri_q == n_m1) begin
                ri_q <= '0;
                ci_q <= ci_q + 4'd1;
            end else begin
                ri_q <= ri_q + 4'd1;
            end
        end
    end

    // BASE + (Rb*N + ri)*STRIDE + Cb*N + ci.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        row  = '0;
        sum  = '0;
        row  = 19'(rb) * 19'(blk_n) + 19'(ri_q);
        sum  = 19'(base) + row * 19'(stride) + 19'(cb) * 19'(blk_n) + 19'(ci_q);
        addr = 18'(sum);
    end
endmodule

// File: rtl/sp_block_fetch.sv
// Fetches one N x N block of 16-bit S' samples for plane Y/U/V from SRAM and
// writes vertically adjacent pairs {even row, odd row} as 32-bit DP-RAM words.
// Build macro SP_BLOCK_FETCH_CHECKSUM_EN adds an XOR checksum of the captured samples.
module sp_block_fetch
    import sp_fetch_pkg::*;
#(
    parameter int SRAM_LAT  = DEF_SRAM_LAT,
    parameter int Y_BASE    = DEF_Y_BASE,
    parameter int U_BASE    = DEF_U_BASE,
    parameter int V_BASE    = DEF_V_BASE,
    parameter int Y_STRIDE  = DEF_Y_STRIDE,
    parameter int UV_STRIDE = DEF_UV_STRIDE,
    parameter int Y_BLK     = DEF_Y_BLK,
    parameter int UV_BLK    = DEF_UV_BLK,
    parameter int DPA_W     = DEF_DPA_W
) (
    input  logic            Clock,
    input  logic            Resetn,
    sp_block_fetch_if.slave bus
);
    fetch_state_t        state_q, state_d;
    plane_t              plane_q;
    logic [4:0]          rb_q;
    logic [5:0]          cb_q;
    logic [17:0]         sel_base;
    logic [8:0]          sel_stride;
    logic [4:0]          sel_n;
    logic [17:0]         gen_addr;
    logic                gen_last;
    logic                accept, kill, issue, capture;
    logic                issue_vld_q;
    logic [SRAM_LAT-1:0] vld_pipe_q;
    logic                odd_q;
    logic [15:0]         held_q;
    logic [DPA_W-1:0]    wptr_q;
    logic [17:0]         sram_addr_q;
    logic                we_q;
    logic [DPA_W-1:0]    waddr_q;
    logic [31:0]         wdata_q;

    // abort outranks start; reserved plane requests are dropped.
    assign accept  = (state_q == IDLE) && bus.start && !bus.abort && (bus.plane != 2'd3);
    assign kill    = bus.abort && (state_q != IDLE);
    assign issue   = (state_q == ISSUE) && bus.sram_gnt && !bus.abort;
    assign capture = vld_pipe_q[SRAM_LAT-1] && !kill;

    // Per-plane geometry from the latched plane.
    always_comb begin
        sel_base   = 18'(Y_BASE);
        sel_stride = 9'(Y_STRIDE);
        sel_n      = 5'(Y_BLK);
        case (plane_q)
            PLANE_U: begin
                sel_base   = 18'(U_BASE);
                sel_stride = 9'(UV_STRIDE);
                sel_n      = 5'(UV_BLK);
            end
            PLANE_V: begin
                sel_base   = 18'(V_BASE);
                sel_stride = 9'(UV_STRIDE);
                sel_n      = 5'(UV_BLK);
            end
            default: ;
        endcase
    end

    sp_addr_gen u_addr_gen (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (accept),
        .step   (issue),
        .blk_n  (sel_n),
        .base   (sel_base),
        .stride (sel_stride),
        .rb     (rb_q),
        .cb     (cb_q),
        .addr   (gen_addr),
        .last   (gen_last)
    );

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: issue N*N addresses, drain the read pipe, pulse done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (issue && gen_last) state_d = DRAIN;
            DRAIN:   if (!issue_vld_q && (vld_pipe_q == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    // Request latch, SRAM address register and read-valid pipe.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            plane_q     <= PLANE_Y;
            rb_q        <= '0;
            cb_q        <= '0;
            sram_addr_q <= '0;
            issue_vld_q <= 1'b0;
            vld_pipe_q  <= '0;
        end else begin
            if (accept) begin
                plane_q <= plane_t'(bus.plane);
                rb_q    <= bus.Rb;
                cb_q    <= bus.Cb;
            end
            if (issue) sram_addr_q <= gen_addr;
            issue_vld_q <= issue;
            if (kill) vld_pipe_q <= '0;
            else      vld_pipe_q <= (vld_pipe_q << 1) | SRAM_LAT'(issue_vld_q);
        end
    end

    // Pair even/odd-row samples and register the DP-RAM write.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            odd_q   <= 1'b0;
            held_q  <= '0;
            wptr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (accept) begin
                odd_q  <= 1'b0;
                wptr_q <= '0;
            end else if (capture) begin
                if (!odd_q) begin
                    held_q <= bus.SRAM_read_data;
                    odd_q  <= 1'b1;
                end else begin
                    we_q    <= 1'b1;
                    waddr_q <= wptr_q;
                    wdata_q <= {held_q, bus.SRAM_read_data};
                    wptr_q  <= wptr_q + DPA_W'(1);
                    odd_q   <= 1'b0;
                end
            end
        end
    end

`ifdef SP_BLOCK_FETCH_CHECKSUM_EN
    logic [15:0] csum_q;

    // XOR of every captured sample; held after done until the next accept.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)      csum_q <= '0;
        else if (accept)  csum_q <= '0;
        else if (capture) csum_q <= csum_q ^ bus.SRAM_read_data;
    end

    assign bus.checksum = csum_q;
`endif

    assign bus.SRAM_address      = sram_addr_q;
    assign bus.DP_RAM_we         = we_q;
    assign bus.DP_RAM_address    = waddr_q;
    assign bus.DP_RAM_write_data = wdata_q;
    assign bus.busy              = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done              = (state_q == DONE);
endmodule

// File: tb/tb_sp_block_fetch.sv
// Bench for sp_block_fetch: two instances (SRAM latency 2 and 3) share one
// stimulus stream; each has its own SRAM model (data = address[15:0]) and scoreboard.
`timescale 1ns/1ps
module tb_sp_block_fetch;
    import sp_fetch_pkg::*;

    localparam int LAT_A = 2;
    localparam int LAT_B = 3;
    localparam int DPA_W = 8;

    typedef struct packed {
        logic [DPA_W-1:0] addr;
        logic [31:0]      data;
    } word_t;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       start, abort, gnt, gnt_rand;
    logic [1:0] plane;
    logic [4:0] rb;
    logic [5:0] cb;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    word_t q_a[$], q_b[$];
    word_t w_a, w_b;
    int    wr_a, wr_b, done_a, done_b;
    int    last_we_a, last_we_b, done_cyc_a, done_cyc_b;
    logic [31:0] first_a;
    logic [15:0] xor_exp;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    sp_block_fetch_if #(.DPA_W(DPA_W)) bus_a ();
    sp_block_fetch_if #(.DPA_W(DPA_W)) bus_b ();

    assign bus_a.start = start;  assign bus_b.start = start;
    assign bus_a.plane = plane;  assign bus_b.plane = plane;
    assign bus_a.Rb    = rb;     assign bus_b.Rb    = rb;
    assign bus_a.Cb    = cb;     assign bus_b.Cb    = cb;
    assign bus_a.abort = abort;  assign bus_b.abort = abort;
    assign bus_a.sram_gnt = gnt; assign bus_b.sram_gnt = gnt;

    // SRAM models: address presented in cycle c returns data in cycle c+LAT.
    logic [17:0] pa_a [LAT_A];
    logic [17:0] pa_b [LAT_B];
    always @(posedge Clock) begin
        pa_a[0] <= bus_a.SRAM_address;
        for (int i = 1; i < LAT_A; i++) pa_a[i] <= pa_a[i-1];
        pa_b[0] <= bus_b.SRAM_address;
        for (int i = 1; i < LAT_B; i++) pa_b[i] <= pa_b[i-1];
    end
    assign bus_a.SRAM_read_data = pa_a[LAT_A-1][15:0];
    assign bus_b.SRAM_read_data = pa_b[LAT_B-1][15:0];

    sp_block_fetch #(.SRAM_LAT(LAT_A), .DPA_W(DPA_W)) u_dut_a (
        .Clock(Clock), .Resetn(Resetn), .bus(bus_a));
    sp_block_fetch #(.SRAM_LAT(LAT_B), .DPA_W(DPA_W)) u_dut_b (
        .Clock(Clock), .Resetn(Resetn), .bus(bus_b));

    // Random grant while gnt_rand is set.
    always @(negedge Clock) if (gnt_rand) gnt = ($urandom_range(0, 2) != 0);

    // Scoreboard for instance A.
    always @(negedge Clock) begin
        if (bus_a.DP_RAM_we === 1'b1) begin
            vectors++;
            if (q_a.size() == 0) begin
                miscompares++;
                $display("FAIL wr_a_unexpected addr=%0d data=%h", bus_a.DP_RAM_address, bus_a.DP_RAM_write_data);
            end else begin
                w_a = q_a.pop_front();
                if (bus_a.DP_RAM_address !== w_a.addr || bus_a.DP_RAM_write_data !== w_a.data) begin
                    miscompares++;
                    $display("FAIL wr_a got addr=%0d data=%h exp addr=%0d data=%h",
                             bus_a.DP_RAM_address, bus_a.DP_RAM_write_data, w_a.addr, w_a.data);
                end
            end
            if (wr_a == 0) first_a = bus_a.DP_RAM_write_data;
            wr_a++;
            last_we_a = cyc;
        end
        if (bus_a.done === 1'b1) begin
            done_a++;
            done_cyc_a = cyc;
        end
    end

    // Scoreboard for instance B.
    always @(negedge Clock) begin
        if (bus_b.DP_RAM_we === 1'b1) begin
            vectors++;
            if (q_b.size() == 0) begin
                miscompares++;
                $display("FAIL wr_b_unexpected addr=%0d data=%h", bus_b.DP_RAM_address, bus_b.DP_RAM_write_data);
            end else begin
                w_b = q_b.pop_front();
                if (bus_b.DP_RAM_address !== w_b.addr || bus_b.DP_RAM_write_data !== w_b.data) begin
                    miscompares++;
                    $display("FAIL wr_b got addr=%0d data=%h exp addr=%0d data=%h",
                             bus_b.DP_RAM_address, bus_b.DP_RAM_write_data, w_b.addr, w_b.data);
                end
            end
            wr_b++;
            last_we_b = cyc;
        end
        if (bus_b.done === 1'b1) begin
            done_b++;
            done_cyc_b = cyc;
        end
    end

    function automatic int blk_of(input int pl);
        return (pl == 0) ? 16 : 8;
    endfunction

    function automatic logic [17:0] exp_addr(input int pl, input int rbi, input int cbi,
                                             input int ri, input int ci);
        int base, stride, n, a;
        base   = (pl == 0) ? 27648 : (pl == 1) ? 55296 : 69120;
        stride = (pl == 0) ? 320 : 160;
        n      = blk_of(pl);
        a      = base + (rbi * n + ri) * stride + cbi * n + ci;
        return 18'(a & 32'h3FFFF);
    endfunction

    // Push the expected DP-RAM words of one block into both scoreboards.
    task automatic push_expected(input int pl, input int rbi, input int cbi);
        int n, w;
        logic [17:0] a0, a1;
        word_t e;
        n = blk_of(pl);
        w = 0;
        xor_exp = '0;
        for (int ci = 0; ci < n; ci++) begin
            for (int ri = 0; ri < n; ri += 2) begin
                a0 = exp_addr(pl, rbi, cbi, ri, ci);
                a1 = exp_addr(pl, rbi, cbi, ri + 1, ci);
                e.addr = DPA_W'(w);
                e.data = {a0[15:0], a1[15:0]};
                q_a.push_back(e);
                q_b.push_back(e);
                xor_exp = xor_exp ^ a0[15:0] ^ a1[15:0];
                w++;
            end
        end
        wr_a = 0;
        wr_b = 0;
    endtask

    // One-cycle start pulse; returns the cycle index of the accepting edge.
    task automatic start_fetch(input int pl, input int rbi, input int cbi, output int s_cyc);
        @(negedge Clock);
        plane = 2'(pl); rb = 5'(rbi); cb = 6'(cbi); start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_done(input int da0, input int db0);
        for (int i = 0; i < 3000 && !(done_a > da0 && done_b > db0); i++) @(negedge Clock);
        vectors++;
        if (!(done_a > da0 && done_b > db0)) begin
            miscompares++;
            $display("FAIL done_timeout done_a=%0d done_b=%0d", done_a - da0, done_b - db0);
        end
        repeat (3) @(negedge Clock);
    endtask

    task automatic check_fetch(input string name, input int n, input int s_cyc,
                               input bit timing, input int da0, input int db0);
        vectors++;
        if (wr_a !== n * n / 2 || wr_b !== n * n / 2 || q_a.size() != 0 || q_b.size() != 0) begin
            miscompares++;
            $display("FAIL %s_count wr_a=%0d wr_b=%0d left=%0d/%0d exp=%0d",
                     name, wr_a, wr_b, q_a.size(), q_b.size(), n * n / 2);
        end
        vectors++;
        if (done_a - da0 != 1 || done_b - db0 != 1) begin
            miscompares++;
            $display("FAIL %s_done_pulses a=%0d b=%0d exp=1", name, done_a - da0, done_b - db0);
        end
        if (timing) begin
            vectors++;
            if (last_we_a - s_cyc != n * n + 1 + LAT_A || done_cyc_a - s_cyc != n * n + 2 + LAT_A) begin
                miscompares++;
                $display("FAIL %s_timing_a last_we=%0d done=%0d exp %0d/%0d", name,
                         last_we_a - s_cyc, done_cyc_a - s_cyc, n * n + 1 + LAT_A, n * n + 2 + LAT_A);
            end
            vectors++;
            if (last_we_b - s_cyc != n * n + 1 + LAT_B || done_cyc_b - s_cyc != n * n + 2 + LAT_B) begin
                miscompares++;
                $display("FAIL %s_timing_b last_we=%0d done=%0d exp %0d/%0d", name,
                         last_we_b - s_cyc, done_cyc_b - s_cyc, n * n + 1 + LAT_B, n * n + 2 + LAT_B);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({bus_a.busy, bus_a.done, bus_a.DP_RAM_we, bus_b.busy, bus_b.done, bus_b.DP_RAM_we} !== 6'b0 ||
            bus_a.SRAM_address !== 18'd0 || bus_b.SRAM_address !== 18'd0 ||
            bus_a.DP_RAM_address !== '0 || bus_b.DP_RAM_address !== '0 ||
            bus_a.DP_RAM_write_data !== 32'd0 || bus_b.DP_RAM_write_data !== 32'd0) begin
            miscompares++;
            $display("FAIL %s busy=%b/%b done=%b/%b we=%b/%b sa=%0d/%0d exp all 0", name,
                     bus_a.busy, bus_b.busy, bus_a.done, bus_b.done, bus_a.DP_RAM_we, bus_b.DP_RAM_we,
                     bus_a.SRAM_address, bus_b.SRAM_address);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; start = 1'b0; abort = 1'b0; gnt = 1'b1; gnt_rand = 1'b0;
        plane = '0; rb = '0; cb = '0;
        repeat (3) @(negedge Clock);
        check_idle_outputs("reset_held");
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_y_fetch();
        int s, da0, db0;
        push_expected(0, 0, 0);
        da0 = done_a; db0 = done_b;
        start_fetch(0, 0, 0, s);
        vectors++;
        if (bus_a.busy !== 1'b1 || bus_b.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL y_busy_on_accept got %b/%b exp 1", bus_a.busy, bus_b.busy);
        end
        wait_done(da0, db0);
        check_fetch("y", 16, s, 1'b1, da0, db0);
        vectors++;
        if (first_a !== {16'd27648, 16'd27968}) begin
            miscompares++;
            $display("FAIL y_word0 got %h exp %h", first_a, {16'd27648, 16'd27968});
        end
    endtask

    task automatic test_u_fetch();
        int s, da0, db0;
        push_expected(1, 2, 3);
        da0 = done_a; db0 = done_b;
        start_fetch(1, 2, 3, s);
        @(negedge Clock);
        vectors++;
        if (bus_a.SRAM_address !== 18'd57880 || bus_b.SRAM_address !== 18'd57880) begin
            miscompares++;
            $display("FAIL u_first_addr got %0d/%0d exp 57880", bus_a.SRAM_address, bus_b.SRAM_address);
        end
        wait_done(da0, db0);
        check_fetch("u", 8, s, 1'b1, da0, db0);
`ifdef SP_BLOCK_FETCH_CHECKSUM_EN
        vectors++;
        if (bus_a.checksum !== xor_exp || bus_b.checksum !== xor_exp) begin
            miscompares++;
            $display("FAIL u_checksum got %h/%h exp %h", bus_a.checksum, bus_b.checksum, xor_exp);
        end
`endif
    endtask

    task automatic test_gnt_toggle();
        int s, da0, db0;
        push_expected(2, 3, 5);
        da0 = done_a; db0 = done_b;
        gnt_rand = 1'b1;
        start_fetch(2, 3, 5, s);
        wait_done(da0, db0);
        gnt_rand = 1'b0;
        gnt = 1'b1;
        check_fetch("v_gnt", 8, s, 1'b0, da0, db0);
    endtask

    task automatic test_abort();
        int s, da0, db0;
        push_expected(0, 0, 0);
        da0 = done_a; db0 = done_b;
        start_fetch(0, 0, 0, s);
        repeat (20 - (cyc - s)) @(negedge Clock);
        abort = 1'b1;
        @(negedge Clock);
        abort = 1'b0;
        vectors++;
        if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0 || bus_a.DP_RAM_we !== 1'b0 || bus_b.DP_RAM_we !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_next_cycle busy=%b/%b we=%b/%b exp 0",
                     bus_a.busy, bus_b.busy, bus_a.DP_RAM_we, bus_b.DP_RAM_we);
        end
        q_a.delete();
        q_b.delete();
        repeat (40) @(negedge Clock);
        vectors++;
        if (done_a != da0 || done_b != db0 || wr_a != 8 || wr_b != 8) begin
            miscompares++;
            $display("FAIL abort_aftermath done=%0d/%0d writes=%0d/%0d exp 0 done, 8 writes",
                     done_a - da0, done_b - db0, wr_a, wr_b);
        end
        test_y_fetch();
    endtask

    task automatic test_ignored();
        int s, da0, db0;
        logic [17:0] sa0;
        sa0 = bus_a.SRAM_address;
        @(negedge Clock);
        plane = 2'd3; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        vectors++;
        if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0 || bus_a.SRAM_address !== sa0) begin
            miscompares++;
            $display("FAIL rsvd_plane busy=%b/%b sa=%0d exp 0/0/%0d", bus_a.busy, bus_b.busy, bus_a.SRAM_address, sa0);
        end
        plane = 2'd0; start = 1'b1; abort = 1'b1;
        @(negedge Clock);
        start = 1'b0; abort = 1'b0;
        @(negedge Clock);
        vectors++;
        if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_beats_start busy=%b/%b exp 0", bus_a.busy, bus_b.busy);
        end
        push_expected(2, 1, 2);
        da0 = done_a; db0 = done_b;
        start_fetch(2, 1, 2, s);
        repeat (10) @(negedge Clock);
        plane = 2'd1; rb = 5'd0; cb = 6'd0; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        vectors++;
        if (bus_a.busy !== 1'b1 || bus_b.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_while_busy busy=%b/%b exp 1", bus_a.busy, bus_b.busy);
        end
        wait_done(da0, db0);
        check_fetch("busy_start", 8, s, 1'b1, da0, db0);
        vectors++;
        if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_restart busy=%b/%b exp 0", bus_a.busy, bus_b.busy);
        end
    endtask

    task automatic test_reset_drain();
        int s;
        push_expected(0, 0, 0);
        start_fetch(0, 0, 0, s);
        repeat (257 - (cyc - s)) @(negedge Clock);
        vectors++;
        if (bus_a.busy !== 1'b1 || bus_b.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_busy got %b/%b exp 1", bus_a.busy, bus_b.busy);
        end
        #1 Resetn = 1'b0;
        #1 check_idle_outputs("reset_in_drain");
        q_a.delete();
        q_b.delete();
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        check_idle_outputs("after_drain_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        wr_a = 0; wr_b = 0; done_a = 0; done_b = 0;
        test_reset();
        test_y_fetch();
        test_u_fetch();
        test_gnt_toggle();
        test_abort();
        test_ignored();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
